// File: rtl/config_pkg.sv
// Shared constants, opcode table and FSM state type for the ALU result packer.
package config_pkg;

  localparam int unsigned HDR_BYTES = 4;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'hAC;
  localparam logic [7:0] OP_DIV  = 8'hD1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } tx_state_e;

  // Payload byte count carried by each opcode; unknown opcodes use the 32-bit form.
  function automatic logic [3:0] payload_len(input logic [7:0] opcode);
    case (opcode)
      OP_ECHO: return 4'd1;
      OP_ADD:  return 4'd4;
      OP_MUL:  return 4'd8;
      OP_DIV:  return 4'd4;
      default: return 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/tx_byte_mux.sv
// Selects the outgoing byte: header fields in HDR, little-endian result bytes in DATA.
module tx_byte_mux
  import config_pkg::*;
#(
  parameter int unsigned HDR_LEN = config_pkg::HDR_BYTES
) (
  input  tx_state_e   state_i,
  input  logic [2:0]  idx_i,
  input  logic [7:0]  opcode_i,
  input  logic [63:0] result_i,
  input  logic [3:0]  len_i,
  output logic [7:0]  byte_o
);

  logic [7:0] w_total_len;

  assign w_total_len = 8'(HDR_LEN) + {4'b0000, len_i};

  always_comb begin
    byte_o = '0;
    case (state_i)
      HDR: begin
        case (idx_i)
          3'd0:    byte_o = opcode_i;
          3'd2:    byte_o = w_total_len;
          default: byte_o = '0;
        endcase
      end
      DATA:    byte_o = result_i[{idx_i, 3'b000} +: 8];
      default: byte_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_tx.sv
// Captures one ALU result and streams it as a header + little-endian payload packet
// over a valid/ready byte interface toward the UART transmitter.
module alu_result_tx #(
  parameter int unsigned HDR_BYTES = config_pkg::HDR_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  opcode_i,
  input  logic [63:0] result_i,
  input  logic        result_valid_i,
  output logic        result_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        done_o
);
  import config_pkg::*;

  tx_state_e   r_state;
  tx_state_e   w_state_nxt;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  r_opcode;
  logic [63:0] r_result;
  logic        r_done;
  logic        w_done_nxt;
  logic        w_capture;
  logic        w_hs;
  logic [3:0]  w_len;
  logic        w_hdr_last;
  logic        w_data_last;

  assign w_len       = payload_len(r_opcode);
  assign w_capture   = (r_state == IDLE) && result_valid_i;
  assign w_hs        = tx_valid_o && tx_ready_i;
  assign w_hdr_last  = (r_idx == 3'(HDR_BYTES - 1));
  assign w_data_last = (r_idx == 3'(w_len - 4'd1));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_state_nxt = HDR;
          w_idx_nxt   = '0;
        end
      end
      HDR: begin
        if (w_hs) begin
          if (w_hdr_last) begin
            w_state_nxt = DATA;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      DATA: begin
        if (w_hs) begin
          if (w_data_last) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode <= '0;
      r_result <= '0;
    end else if (w_capture) begin
      r_opcode <= opcode_i;
      r_result <= result_i;
    end
  end

  tx_byte_mux #(
    .HDR_LEN(HDR_BYTES)
  ) u_byte_mux (
    .state_i  (r_state),
    .idx_i    (r_idx),
    .opcode_i (r_opcode),
    .result_i (r_result),
    .len_i    (w_len),
    .byte_o   (tx_data_o)
  );

  assign busy_o         = (r_state != IDLE);
  assign tx_valid_o     = busy_o;
  assign result_ready_o = ~busy_o;
  assign done_o         = r_done;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed checks of the ALU result packer: packet contents, timing, backpressure,
// busy refusal and asynchronous reset mid-packet.
module tb_alu_result_tx;

  logic        clk;
  logic        rst;
  logic [7:0]  opcode_i;
  logic [63:0] result_i;
  logic        result_valid_i;
  logic        result_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        done_o;

  int checks;
  int failures;
  logic [7:0] exq[$];

  alu_result_tx dut (
    .clk            (clk),
    .rst            (rst),
    .opcode_i       (opcode_i),
    .result_i       (result_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a result for one edge, then scramble the inputs to prove they were latched.
  task automatic capture(input logic [7:0] op, input logic [63:0] res);
    result_valid_i = 1'b1;
    opcode_i       = op;
    result_i       = res;
    chk("ready_before_capture", 64'(result_ready_o), 64'd1);
    step();
    result_valid_i = 1'b0;
    opcode_i       = 8'h5A;
    result_i       = '1;
  endtask

  // Walk exq byte by byte from cycle k+1; optionally stall stall_n cycles at byte stall_at.
  task automatic expect_stream(input string tag, input int stall_at, input int stall_n);
    for (int i = 0; i < exq.size(); i++) begin
      if (i == stall_at) begin
        tx_ready_i = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk({tag, "_stall_valid"}, 64'(tx_valid_o), 64'd1);
          chk({tag, "_stall_data"}, 64'(tx_data_o), 64'(exq[i]));
          step();
        end
        tx_ready_i = 1'b1;
      end
      chk({tag, "_valid"}, 64'(tx_valid_o), 64'd1);
      chk({tag, "_data"}, 64'(tx_data_o), 64'(exq[i]));
      chk({tag, "_busy"}, 64'(busy_o), 64'd1);
      chk({tag, "_ready_while_busy"}, 64'(result_ready_o), 64'd0);
      chk({tag, "_no_early_done"}, 64'(done_o), 64'd0);
      step();
    end
    chk({tag, "_done_pulse"}, 64'(done_o), 64'd1);
    chk({tag, "_valid_after"}, 64'(tx_valid_o), 64'd0);
    chk({tag, "_ready_after"}, 64'(result_ready_o), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
    step();
    chk({tag, "_done_one_cycle"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    opcode_i       = '0;
    result_i       = '0;
    result_valid_i = 1'b1;
    tx_ready_i     = 1'b1;
    #1;
    chk("rst_tx_valid", 64'(tx_valid_o), 64'd0);
    chk("rst_tx_data", 64'(tx_data_o), 64'h00);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ready", 64'(result_ready_o), 64'd1);
    step();
    step();
    chk("rst_no_capture", 64'(busy_o), 64'd0);
    result_valid_i = 1'b0;
    rst = 1'b0;
    step();
    chk("idle_after_rst", 64'(tx_valid_o), 64'd0);

    // Add result, full-rate stream.
    capture(8'hAD, 64'h0000_0000_1234_5678);
    exq = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    expect_stream("add", -1, 0);

    // Mult result, 8-byte payload.
    capture(8'hAC, 64'h0000_0001_0000_0002);
    exq = '{8'hAC, 8'h00, 8'h0C, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
            8'h01, 8'h00, 8'h00, 8'h00};
    expect_stream("mul", -1, 0);

    // Echo result: only the low byte goes out, busy for exactly five cycles.
    capture(8'hEC, 64'h0000_0000_0000_0041);
    exq = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h41};
    expect_stream("echo", -1, 0);

    // Add result with a 3-cycle stall on the length byte.
    capture(8'hAD, 64'h0000_0000_1234_5678);
    exq = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    expect_stream("add_bp", 2, 3);

    // Busy refusal: a D1 offer held throughout an add packet starts right after done.
    capture(8'hAD, 64'h0000_0000_1234_5678);
    result_valid_i = 1'b1;
    opcode_i       = 8'hD1;
    result_i       = 64'hCAFE_BABE_DEAD_BEEF;
    exq = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    expect_stream("add_refuse", -1, 0);
    result_valid_i = 1'b0;
    opcode_i       = 8'h00;
    result_i       = '0;
    exq = '{8'hD1, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    expect_stream("div", -1, 0);

    // Reset while payload byte 2 is on the stream.
    capture(8'hAD, 64'h0000_0000_1234_5678);
    exq = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34};
    for (int i = 0; i < exq.size() - 1; i++) begin
      chk("pre_rst_data", 64'(tx_data_o), 64'(exq[i]));
      step();
    end
    chk("pre_rst_payload2", 64'(tx_data_o), 64'h34);
    chk("pre_rst_valid", 64'(tx_valid_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(tx_valid_o), 64'd0);
    chk("async_rst_data", 64'(tx_data_o), 64'h00);
    chk("async_rst_busy", 64'(busy_o), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(result_ready_o), 64'd1);
    chk("post_rst_valid", 64'(tx_valid_o), 64'd0);
    chk("post_rst_done", 64'(done_o), 64'd0);
    capture(8'hAD, 64'h0000_0000_1234_5678);
    exq = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    expect_stream("add_after_rst", -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
